// File: rtl/gp_reg_pkg.sv
// Shared constants and types for the general-purpose register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gp_reg_pkg;

  localparam int          GP_REG_WIDTH       = 8;
  localparam logic [7:0]  GP_REG_RESET_VALUE = 8'h00;

  typedef logic [GP_REG_WIDTH-1:0] gp_word_t;

endpackage

// File: rtl/tristate_buf.sv
// Active-low enabled tri-state driver onto a shared bus.
// Latency: combinational, zero cycles.
// Backpressure: none; the bus is released to Z whenever n_oe is high.
//
// Ports:
//   d     in  WIDTH  value to drive
//   n_oe  in  1      active-low output enable
//   y     out WIDTH  d when n_oe=0, otherwise all bits Z
module tristate_buf #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] d,
  input  logic             n_oe,
  output wire  [WIDTH-1:0] y
);

  assign y = n_oe ? {WIDTH{1'bz}} : d;

endmodule

// File: rtl/gp_reg_b.sv
// General-purpose register: one write port, two independently enabled tri-state read ports.
// Latency: write visible one w_clk rising edge later; read enables are combinational.
// Backpressure: none; the register loads di on every edge unless rst is high.
//
// Ports:
//   w_clk   in  1      write clock, rising-edge
//   rst     in  1      synchronous active-high reset, loads RESET_VALUE
//   di      in  WIDTH  write data
//   n_oe_a  in  1      active-low enable for read port A
//   n_oe_b  in  1      active-low enable for read port B
//   doa     out WIDTH  read port A (Z when disabled)
//   dob     out WIDTH  read port B (Z when disabled)
//
// Optional build macro GP_REG_B_ASSERT_EN compiles in simulation-only X/Z checks
// on the control and data inputs; the datapath is identical either way.
module gp_reg_b
  import gp_reg_pkg::*;
#(
  parameter int               WIDTH       = GP_REG_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(GP_REG_RESET_VALUE)
) (
  input  logic             w_clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] di,
  input  logic             n_oe_a,
  input  logic             n_oe_b,
  output wire  [WIDTH-1:0] doa,
  output wire  [WIDTH-1:0] dob
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // No write enable: every edge captures di unless reset overrides it.
  always_comb begin
    q_d = di;
  end

  always_ff @(posedge w_clk) begin
    if (rst) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  tristate_buf #(.WIDTH(WIDTH)) u_buf_a (
    .d    (q_q),
    .n_oe (n_oe_a),
    .y    (doa)
  );

  tristate_buf #(.WIDTH(WIDTH)) u_buf_b (
    .d    (q_q),
    .n_oe (n_oe_b),
    .y    (dob)
  );

`ifdef GP_REG_B_ASSERT_EN
  // Enables are only meaningful once the register holds a defined value,
  // so their X/Z check is armed by the first observed reset.
  logic seen_rst_q;

  always_ff @(posedge w_clk) begin
    if (rst === 1'b1) begin
      seen_rst_q <= 1'b1;
    end
  end

  always @* begin
    if (seen_rst_q === 1'b1) begin
      assert (!$isunknown({n_oe_a, n_oe_b}))
        else $error("gp_reg_b: output enable is X/Z");
    end
  end

  always @(posedge w_clk) begin
    assert (!$isunknown(rst))
      else $error("gp_reg_b: rst is X/Z at w_clk edge");
    if (rst === 1'b0) begin
      assert (!$isunknown(di))
        else $error("gp_reg_b: di is X/Z at w_clk edge");
    end
  end
`endif

endmodule

// File: tb/tb_gp_reg_b.sv
// Self-checking bench for gp_reg_b: directed sequence followed by randomized traffic.
// Z detection: two DUT copies share all inputs; one drives pulled-up nets, the other
// pulled-down nets, so a released port reads all-ones on one and all-zeros on the other.
module tb_gp_reg_b;

  localparam int W = 8;

  logic         w_clk;
  logic         rst;
  logic [W-1:0] di;
  logic         n_oe_a;
  logic         n_oe_b;

  tri1  [W-1:0] doa_pu;
  tri1  [W-1:0] dob_pu;
  tri0  [W-1:0] doa_pd;
  tri0  [W-1:0] dob_pd;

  gp_reg_b u_dut_pu (
    .w_clk  (w_clk),
    .rst    (rst),
    .di     (di),
    .n_oe_a (n_oe_a),
    .n_oe_b (n_oe_b),
    .doa    (doa_pu),
    .dob    (dob_pu)
  );

  gp_reg_b u_dut_pd (
    .w_clk  (w_clk),
    .rst    (rst),
    .di     (di),
    .n_oe_a (n_oe_a),
    .n_oe_b (n_oe_b),
    .doa    (doa_pd),
    .dob    (dob_pd)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the stored byte as seen from the outside.
  logic [W-1:0] model_q;

  task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed pu/pd=%h required pu/pd=%h", tag, obs, exp);
    end
  endtask

  // Expected {pulled-up view, pulled-down view} of one port.
  function automatic logic [2*W-1:0] port_exp(input logic n_oe, input logic [W-1:0] q);
    if (n_oe) return {{W{1'b1}}, {W{1'b0}}};
    return {q, q};
  endfunction

  task automatic check_ports(input string tag);
    check({tag, "/a"}, {doa_pu, doa_pd}, port_exp(n_oe_a, model_q));
    check({tag, "/b"}, {dob_pu, dob_pd}, port_exp(n_oe_b, model_q));
  endtask

  task automatic rise();
    #5 w_clk = 1'b1;
    model_q = rst ? 8'h00 : di;
    #1;
  endtask

  task automatic fall();
    #5 w_clk = 1'b0;
    #1;
  endtask

  initial begin
    w_clk  = 1'b0;
    rst    = 1'b1;
    di     = 8'hC3;
    n_oe_a = 1'b1;
    n_oe_b = 1'b1;
    model_q = 8'h00;

    // Reset with both ports disabled.
    rise();
    check_ports("reset_both_off");
    fall();

    n_oe_a = 1'b0; #1;
    check_ports("en_a_only");
    n_oe_b = 1'b0; #1;
    check_ports("en_both_reset_val");
    n_oe_a = 1'b1; #1;
    check_ports("en_b_only");

    // Write on a rising edge.
    rst = 1'b0; di = 8'hC3; #1;
    check_ports("before_edge");
    rise();
    check_ports("write_c3");

    // Data changes with the clock held high, then low, must not load.
    di = 8'hA5; #2;
    check_ports("di_chg_clk_high");
    fall();
    check_ports("clk_fall_no_load");
    n_oe_a = 1'b0; #1;
    check_ports("en_a_shows_c3");

    // Reset wins over new data on the same edge.
    rst = 1'b1; di = 8'hA5; #1;
    rise();
    check_ports("reset_mid_op");
    fall();
    rst = 1'b0; #1;
    rise();
    check_ports("load_after_reset");
    fall();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: begin
          n_oe_a = 1'($urandom);
          n_oe_b = 1'($urandom);
          #($urandom_range(1, 4));
          check_ports("rnd_enable");
        end
        1: begin
          di = 8'($urandom);
          #($urandom_range(1, 4));
          check_ports("rnd_di_no_edge");
        end
        default: begin
          rst = ($urandom_range(0, 9) == 0);
          di  = 8'($urandom);
          rise();
          check_ports("rnd_edge");
          di = 8'($urandom);
          #2;
          check_ports("rnd_di_clk_high");
          fall();
        end
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
